// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP ALU issue/capture stage: op codes, FSM states
// and the default datapath width.
package fp_alu_pkg;

   localparam int DEFAULT_BUS_WIDTH = 32;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;
   localparam logic [1:0] OP_ABS = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } issue_state_t;

endpackage

// File: rtl/fp_alu_issue_if.sv
// Bundle of request, ALU-side and result-side signals of the issue stage.
// The issue stage uses the slave view; whoever feeds it and hosts the ALU uses master.
interface fp_alu_issue_if #(
   parameter int BUS_WIDTH = fp_alu_pkg::DEFAULT_BUS_WIDTH,
   parameter int CNT_WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [BUS_WIDTH-1:0] in_a;
   logic [BUS_WIDTH-1:0] in_b;
   logic [1:0]           in_op;

   logic [BUS_WIDTH-1:0] alu_a;
   logic [BUS_WIDTH-1:0] alu_b;
   logic [1:0]           alu_op;
   logic [BUS_WIDTH-1:0] alu_result;
   logic                 alu_neg;
   logic                 alu_zero;

   logic                 out_valid;
   logic                 out_ready;
   logic [BUS_WIDTH-1:0] out_data;
   logic                 out_neg;
   logic                 out_zero;
   logic                 out_divz;
   logic [1:0]           out_op;

   logic                 busy;
   logic [CNT_WIDTH-1:0] ops_done;

   modport slave (
      input  in_valid, in_a, in_b, in_op,
      output in_ready,
      output alu_a, alu_b, alu_op,
      input  alu_result, alu_neg, alu_zero,
      output out_valid, out_data, out_neg, out_zero, out_divz, out_op,
      input  out_ready,
      output busy, ops_done
   );

   modport master (
      output in_valid, in_a, in_b, in_op,
      input  in_ready,
      input  alu_a, alu_b, alu_op,
      output alu_result, alu_neg, alu_zero,
      input  out_valid, out_data, out_neg, out_zero, out_divz, out_op,
      output out_ready,
      input  busy, ops_done
   );
endinterface

// File: rtl/fp_alu_req_fifo.sv
// Synchronous request FIFO with a registered occupancy count; the count carries
// the extra bit that tells full from empty when the pointers coincide.
module fp_alu_req_fifo #(
   parameter int WIDTH = 66,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rdPtr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/fp_alu_issue.sv
// Issue/capture stage around the combinational FP ALU: queues requests, holds
// operands stable for a fixed settle time, then registers result and flags.
module fp_alu_issue
   import fp_alu_pkg::*;
#(
   parameter int BUS_WIDTH     = DEFAULT_BUS_WIDTH,
   parameter int FIFO_DEPTH    = 4,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_WIDTH     = 16
) (
   input  logic           clk,
   input  logic           rst,
   fp_alu_issue_if.slave  bus
);
   localparam int FW = 2*BUS_WIDTH + 2;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic [AW:0]          w_count;
   logic [FW-1:0]        w_head;

   issue_state_t         r_state;
   logic [CW-1:0]        r_cnt;
   logic [BUS_WIDTH-1:0] r_aluA;
   logic [BUS_WIDTH-1:0] r_aluB;
   logic [1:0]           r_aluOp;
   logic                 r_outValid;
   logic [BUS_WIDTH-1:0] r_outData;
   logic                 r_outNeg;
   logic                 r_outZero;
   logic                 r_outDivz;
   logic [1:0]           r_outOp;
   logic [CNT_WIDTH-1:0] r_opsDone;

   assign bus.in_ready = ~w_full & ~rst;
   assign w_push       = bus.in_valid & bus.in_ready;
   // A new entry is taken from IDLE, or from HOLD in the same cycle the result leaves.
   assign w_pop = ~w_empty & ((r_state == ST_IDLE) |
                              ((r_state == ST_HOLD) & bus.out_ready));

   fp_alu_req_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  ({bus.in_op, bus.in_a, bus.in_b}),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_aluA     <= '0;
         r_aluB     <= '0;
         r_aluOp    <= '0;
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outNeg   <= 1'b0;
         r_outZero  <= 1'b0;
         r_outDivz  <= 1'b0;
         r_outOp    <= '0;
         r_opsDone  <= '0;
      end else begin
         if (w_pop) begin
            r_aluOp <= w_head[FW-1 -: 2];
            r_aluA  <= w_head[2*BUS_WIDTH-1 -: BUS_WIDTH];
            r_aluB  <= w_head[BUS_WIDTH-1:0];
            r_cnt   <= CW'(SETTLE_CYCLES - 1);
         end
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_cnt == '0) begin
                  r_outData  <= bus.alu_result;
                  r_outNeg   <= bus.alu_neg;
                  r_outZero  <= bus.alu_zero;
                  r_outDivz  <= (r_aluOp == OP_DIV) && (r_aluB[BUS_WIDTH-2:0] == '0);
                  r_outOp    <= r_aluOp;
                  r_outValid <= 1'b1;
                  r_state    <= ST_HOLD;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  r_outValid <= 1'b0;
                  r_opsDone  <= r_opsDone + 1'b1;
                  r_state    <= w_pop ? ST_SETTLE : ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.alu_a     = r_aluA;
   assign bus.alu_b     = r_aluB;
   assign bus.alu_op    = r_aluOp;
   assign bus.out_valid = r_outValid;
   assign bus.out_data  = r_outData;
   assign bus.out_neg   = r_outNeg;
   assign bus.out_zero  = r_outZero;
   assign bus.out_divz  = r_outDivz;
   assign bus.out_op    = r_outOp;
   assign bus.ops_done  = r_opsDone;
   assign bus.busy      = (r_state != ST_IDLE) || (w_count != '0);
endmodule
